// File: rtl/shift_ctr_pkg.sv
// Shared definitions for the shift_counter family.
//   MODE_RING / MODE_JOHNSON : values of the mode input
//   DIR_UP / DIR_DOWN        : values of the dir input (toward MSB / toward LSB)
//   home_code(mode, width)   : home state of the selected sequence, masked to width bits
package shift_ctr_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Ring home is bit0 set; Johnson home is all zeros.
  function automatic logic [63:0] home_code(input logic mode, input int unsigned width);
    logic [63:0] mask;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (mode == MODE_JOHNSON) ? 64'd0 : (64'd1 & mask);
  endfunction

endpackage

// File: rtl/shift_ctr_check.sv
// Combinational legality check for ring and Johnson codes.
// Ports:
//   out   : WIDTH-bit counter code under test
//   mode  : 0 = ring, 1 = Johnson
//   legal : 1 when out is a member of the selected sequence
module shift_ctr_check
  import shift_ctr_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] out,
  input  logic             mode,
  output logic             legal
);

  logic [WIDTH-2:0] trans;

  // A Johnson code has at most one boundary between its run of ones and run of zeros.
  assign trans = out[WIDTH-1:1] ^ out[WIDTH-2:0];

  always_comb begin
    legal = 1'b0;
    if (mode == MODE_JOHNSON) begin
      legal = ($countones(trans) <= 1);
    end else begin
      legal = ($countones(out) == 1);
    end
  end

endmodule

// File: rtl/shift_counter.sv
// Parametrised ring / Johnson shift counter with direction control, parallel load,
// terminal-count pulse and one-cycle recovery from illegal codes.
// Optional decode of the sequence position is enabled by defining SHIFT_CTR_DECODE_EN;
// without it idx is tied to zero.
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous active-high reset (out <= home of sampled mode)
//   en       : shift one position per cycle while high
//   mode     : 0 = ring, 1 = Johnson
//   dir      : 0 = toward MSB, 1 = toward LSB
//   load     : parallel load strobe, load_val captured next edge
//   load_val : load data
//   out      : registered counter state
//   tc       : registered pulse when an enabled shift lands on home
//   illegal  : combinational, out is not legal for the current mode
//   idx      : decoded sequence position (0 when illegal or decode disabled)
module shift_counter
  import shift_ctr_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IDXW  = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             illegal,
  output logic [IDXW-1:0]  idx
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] home;
  logic [WIDTH-1:0] shifted;
  logic             legal;

  assign home = WIDTH'(home_code(mode, WIDTH));

  shift_ctr_check #(
    .WIDTH (WIDTH)
  ) u_check (
    .out   (out_q),
    .mode  (mode),
    .legal (legal)
  );

  assign illegal = ~legal;

  always_comb begin
    shifted = out_q;
    if (mode == MODE_JOHNSON) begin
      if (dir == DIR_UP) shifted = {out_q[WIDTH-2:0], ~out_q[WIDTH-1]};
      else               shifted = {~out_q[0], out_q[WIDTH-1:1]};
    end else begin
      if (dir == DIR_UP) shifted = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
      else               shifted = {out_q[0], out_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    out_d = out_q;
    tc_d  = 1'b0;
    if (reset) begin
      out_d = home;
    end else if (load) begin
      out_d = load_val;
    end else if (illegal) begin
      // Recovery never raises tc even though it lands on home.
      out_d = home;
    end else if (en) begin
      out_d = shifted;
      tc_d  = (shifted == home);
    end
  end

  always_ff @(posedge clk) begin
    out_q <= out_d;
    tc_q  <= tc_d;
  end

  assign out = out_q;
  assign tc  = tc_q;

`ifdef SHIFT_CTR_DECODE_EN
  int idx_v;

  always_comb begin
    idx_v = 0;
    if (!illegal) begin
      if (mode == MODE_JOHNSON) begin
        // Steps from home along the dir=0 sequence: filling phase, then draining phase.
        if (!out_q[WIDTH-1]) idx_v = $countones(out_q);
        else                 idx_v = 2 * WIDTH - $countones(out_q);
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          if (out_q[i]) idx_v = i;
        end
      end
    end
  end

  assign idx = IDXW'(idx_v);
`else
  assign idx = '0;
`endif

endmodule
